// File: rtl/pwm_capture.sv
// pwm_capture: measures duty/period (in prescaler ticks) and both dead-times of the boost gate pair,
// flags shoot-through (sticky) and a missing s rising edge (stall).
module pwm_capture #(
  parameter int PRESC   = 200,
  parameter int TIMEOUT = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_in,
  input  logic       nots_in,
  input  logic       clr_fault,
  output logic [9:0] duty,
  output logic [11:0] period,
  output logic [7:0] dt_fall,
  output logic [7:0] dt_rise,
  output logic       valid,
  output logic       fault,
  output logic       stall
);
  localparam int PW = $clog2(PRESC);
  logic s_m, s_q, s_d, n_m, n_q, n_d;
  logic [PW-1:0] presc, presc_eff;
  logic [11:0] per_cnt;
  logic [9:0] hi_cnt;
  logic [7:0] dtf_cnt, dtr_cnt;
  logic armed, dtf_run, dtr_run;
  logic s_rise, s_fall, n_rise, n_fall, ovl, tick;
  assign s_rise = s_q & ~s_d;
  assign s_fall = ~s_q & s_d;
  assign n_rise = n_q & ~n_d;
  assign n_fall = ~n_q & n_d;
  assign ovl    = s_q & n_q;
  // the rise cycle itself counts as cycle 0 of the new period, so ticks land on exact multiples of PRESC
  assign presc_eff = s_rise ? '0 : presc;
  assign tick      = presc_eff == PW'(PRESC - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s_m, s_q, s_d, n_m, n_q, n_d} <= '0;
      presc   <= '0;
      per_cnt <= '0;
      hi_cnt  <= '0;
      dtf_cnt <= '0;
      dtr_cnt <= '0;
      dtf_run <= 1'b0;
      dtr_run <= 1'b0;
      armed   <= 1'b0;
      duty    <= '0;
      period  <= '0;
      dt_fall <= '0;
      dt_rise <= '0;
      valid   <= 1'b0;
      fault   <= 1'b0;
      stall   <= 1'b0;
    end else begin
      {s_m, s_q, s_d} <= {s_in, s_m, s_q};
      {n_m, n_q, n_d} <= {nots_in, n_m, n_q};
      presc   <= tick ? '0 : presc_eff + 1'b1;
      per_cnt <= s_rise ? '0 : (tick && per_cnt != '1) ? per_cnt + 12'd1 : per_cnt;
      hi_cnt  <= s_rise ? '0 : (tick && s_q && hi_cnt != '1) ? hi_cnt + 10'd1 : hi_cnt;
      valid   <= s_rise & armed;
      fault   <= ovl | (fault & ~clr_fault);
      if (s_rise) begin
        if (armed) begin
          duty   <= hi_cnt;
          period <= per_cnt;
        end
        armed <= 1'b1;
        stall <= 1'b0;
      end else if (per_cnt == 12'(TIMEOUT)) begin
        armed <= 1'b0;
        stall <= 1'b1;
      end
      if (s_fall) begin
        dtf_run <= 1'b1;
        dtf_cnt <= 8'd1;
      end else if (dtf_run && n_rise) begin
        dtf_run <= 1'b0;
        if (!ovl) dt_fall <= dtf_cnt;
      end else if (s_rise) begin
        dtf_run <= 1'b0;
      end else if (dtf_run) begin
        dtf_cnt <= (dtf_cnt == '1) ? dtf_cnt : dtf_cnt + 8'd1;
      end
      if (n_fall) begin
        dtr_run <= 1'b1;
        dtr_cnt <= 8'd1;
      end else if (dtr_run && s_rise) begin
        dtr_run <= 1'b0;
        if (!ovl) dt_rise <= dtr_cnt;
      end else if (n_rise) begin
        dtr_run <= 1'b0;
      end else if (dtr_run) begin
        dtr_cnt <= (dtr_cnt == '1) ? dtr_cnt : dtr_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture, scaled to PRESC=10 / TIMEOUT=2000 to keep runtime short.
module tb_pwm_capture;
  logic clk = 1'b0, rst_n = 1'b0, s_in = 1'b0, nots_in = 1'b0, clr_fault = 1'b0;
  logic [9:0] duty;
  logic [11:0] period;
  logic [7:0] dt_fall, dt_rise;
  logic valid, fault, stall;
  int pass_cnt = 0, total = 0, cyc_cnt = 0, rise_cyc = 0, vcount = 0, vlat = 0;

  pwm_capture #(.PRESC(10), .TIMEOUT(2000)) dut (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .nots_in(nots_in), .clr_fault(clr_fault),
    .duty(duty), .period(period), .dt_fall(dt_fall), .dt_rise(dt_rise),
    .valid(valid), .fault(fault), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;
  always @(negedge clk) if (valid) begin
    vcount++;
    vlat = cyc_cnt - rise_cyc;
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // s rises at the start; nots is the complement with gap-cycle dead-times on both sides
  task automatic run_period(input int hi, input int per, input int gap);
    s_in = 1'b1;
    rise_cyc = cyc_cnt;
    cyc(hi);
    s_in = 1'b0;
    cyc(gap);
    nots_in = 1'b1;
    cyc(per - hi - 2 * gap);
    nots_in = 1'b0;
    cyc(gap);
  endtask

  task automatic test_reset;
    cyc(5);
    total++; if (duty !== 10'd0 || period !== 12'd0) $display("FAIL reset_in duty=%0d period=%0d exp 0/0", duty, period); else pass_cnt++;
    rst_n = 1'b1;
    cyc(1000);
    total++; if (duty !== 10'd0) $display("FAIL idle_duty got %0d exp 0", duty); else pass_cnt++;
    total++; if (period !== 12'd0) $display("FAIL idle_period got %0d exp 0", period); else pass_cnt++;
    total++; if (dt_fall !== 8'd0 || dt_rise !== 8'd0) $display("FAIL idle_dt got %0d/%0d exp 0/0", dt_fall, dt_rise); else pass_cnt++;
    total++; if ({valid, fault, stall} !== 3'b000) $display("FAIL idle_flags got %b exp 000", {valid, fault, stall}); else pass_cnt++;
    total++; if (vcount !== 0) $display("FAIL idle_valid_pulses got %0d exp 0", vcount); else pass_cnt++;
  endtask

  task automatic test_basic;
    int v0;
    v0 = vcount;
    run_period(300, 1000, 50);
    total++; if (vcount !== v0) $display("FAIL basic_first_rise pulses got %0d exp %0d", vcount, v0); else pass_cnt++;
    run_period(300, 1000, 50);
    run_period(300, 1000, 50);
    total++; if (vcount !== v0 + 2) $display("FAIL basic_pulses got %0d exp %0d", vcount, v0 + 2); else pass_cnt++;
    total++; if (vlat < 3 || vlat > 4) $display("FAIL basic_valid_latency got %0d exp 3..4", vlat); else pass_cnt++;
    total++; if (duty !== 10'd30) $display("FAIL basic_duty got %0d exp 30", duty); else pass_cnt++;
    total++; if (period !== 12'd100) $display("FAIL basic_period got %0d exp 100", period); else pass_cnt++;
    total++; if (dt_fall !== 8'd50) $display("FAIL basic_dt_fall got %0d exp 50", dt_fall); else pass_cnt++;
    total++; if (dt_rise !== 8'd50) $display("FAIL basic_dt_rise got %0d exp 50", dt_rise); else pass_cnt++;
    total++; if (fault !== 1'b0 || stall !== 1'b0) $display("FAIL basic_flags fault=%b stall=%b exp 0/0", fault, stall); else pass_cnt++;
  endtask

  task automatic test_non_integer;
    run_period(309, 1009, 50);
    run_period(310, 1010, 50);
    total++; if (duty !== 10'd30 || period !== 12'd100) $display("FAIL floor_309 got %0d/%0d exp 30/100", duty, period); else pass_cnt++;
    run_period(300, 1000, 50);
    total++; if (duty !== 10'd31 || period !== 12'd101) $display("FAIL floor_310 got %0d/%0d exp 31/101", duty, period); else pass_cnt++;
  endtask

  task automatic test_shoot_through;
    s_in = 1'b1;
    rise_cyc = cyc_cnt;
    cyc(300);
    nots_in = 1'b1;
    cyc(3);
    total++; if (fault !== 1'b1) $display("FAIL shoot_set got %b exp 1", fault); else pass_cnt++;
    clr_fault = 1'b1;
    cyc(1);
    clr_fault = 1'b0;
    total++; if (fault !== 1'b1) $display("FAIL shoot_clr_during got %b exp 1", fault); else pass_cnt++;
    cyc(16);
    s_in = 1'b0;
    cyc(100);
    total++; if (fault !== 1'b1) $display("FAIL shoot_sticky got %b exp 1", fault); else pass_cnt++;
    total++; if (dt_fall !== 8'd50) $display("FAIL shoot_dt_fall_held got %0d exp 50", dt_fall); else pass_cnt++;
    clr_fault = 1'b1;
    cyc(1);
    clr_fault = 1'b0;
    total++; if (fault !== 1'b0) $display("FAIL shoot_clr_after got %b exp 0", fault); else pass_cnt++;
    nots_in = 1'b0;
    cyc(50);
  endtask

  task automatic test_stall;
    int last_rise;
    run_period(300, 1000, 50);
    run_period(300, 1000, 50);
    last_rise = rise_cyc;
    while (cyc_cnt < last_rise + 19995) cyc(1);
    total++; if (stall !== 1'b0) $display("FAIL stall_early got %b exp 0", stall); else pass_cnt++;
    while (cyc_cnt < last_rise + 20005) cyc(1);
    total++; if (stall !== 1'b1) $display("FAIL stall_set got %b exp 1", stall); else pass_cnt++;
    while (cyc_cnt < last_rise + 22000) cyc(1);
    total++; if (duty !== 10'd30 || period !== 12'd100) $display("FAIL stall_hold got %0d/%0d exp 30/100", duty, period); else pass_cnt++;
    total++; if (stall !== 1'b1) $display("FAIL stall_persist got %b exp 1", stall); else pass_cnt++;
  endtask

  task automatic test_resume;
    int v0;
    v0 = vcount;
    run_period(300, 1000, 50);
    total++; if (stall !== 1'b0) $display("FAIL resume_stall got %b exp 0", stall); else pass_cnt++;
    total++; if (vcount !== v0) $display("FAIL resume_first_rise pulses got %0d exp %0d", vcount, v0); else pass_cnt++;
    total++; if (dt_rise !== 8'd255) $display("FAIL resume_dt_rise_sat got %0d exp 255", dt_rise); else pass_cnt++;
    run_period(300, 1000, 50);
    total++; if (vcount !== v0 + 1) $display("FAIL resume_second_rise pulses got %0d exp %0d", vcount, v0 + 1); else pass_cnt++;
    total++; if (dt_rise !== 8'd50) $display("FAIL resume_dt_rise got %0d exp 50", dt_rise); else pass_cnt++;
  endtask

  task automatic test_saturation;
    int v0;
    v0 = vcount;
    run_period(12500, 15000, 50);
    s_in = 1'b1;
    rise_cyc = cyc_cnt;
    cyc(10);
    total++; if (vcount !== v0 + 2) $display("FAIL sat_pulses got %0d exp %0d", vcount, v0 + 2); else pass_cnt++;
    total++; if (duty !== 10'd1023) $display("FAIL sat_duty got %0d exp 1023", duty); else pass_cnt++;
    total++; if (period !== 12'd1500) $display("FAIL sat_period got %0d exp 1500", period); else pass_cnt++;
    cyc(100);
    rst_n = 1'b0;
    s_in = 1'b0;
    nots_in = 1'b0;
    #1;
    total++; if (duty !== 10'd0 || period !== 12'd0) $display("FAIL async_rst got %0d/%0d exp 0/0", duty, period); else pass_cnt++;
    total++; if (dt_fall !== 8'd0 || dt_rise !== 8'd0) $display("FAIL async_rst_dt got %0d/%0d exp 0/0", dt_fall, dt_rise); else pass_cnt++;
    total++; if ({valid, fault, stall} !== 3'b000) $display("FAIL async_rst_flags got %b exp 000", {valid, fault, stall}); else pass_cnt++;
    cyc(3);
    rst_n = 1'b1;
  endtask

  task automatic test_rearm;
    int v0;
    v0 = vcount;
    cyc(100);
    run_period(300, 1000, 50);
    total++; if (vcount !== v0 || duty !== 10'd0) $display("FAIL rearm_first pulses=%0d duty=%0d exp %0d/0", vcount, duty, v0); else pass_cnt++;
    run_period(300, 1000, 50);
    total++; if (vcount !== v0 + 1) $display("FAIL rearm_second pulses got %0d exp %0d", vcount, v0 + 1); else pass_cnt++;
    total++; if (duty !== 10'd30 || period !== 12'd100) $display("FAIL rearm_values got %0d/%0d exp 30/100", duty, period); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_non_integer;
    test_shoot_through;
    test_stall;
    test_resume;
    test_saturation;
    test_rearm;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
